// File: rtl/mem_rr_arbiter.sv
// -----------------------------------------------------------------------------
// mem_rr_arbiter
//
// Round-robin arbiter between NCH requesters (instruction fetch, load/store
// buffer, ...) and a single byte-wide RAM port. A granted request moves
// 1..WORD_BYTES bytes serially, either writing bytes of the latched write word
// or reading bytes that are assembled little-endian into rdata_out.
//
// Transfer sequence (E0 = grant edge):
//   IDLE  -> XFER  : grant, latch request fields, issue byte 0
//   XFER           : issue bytes 1..len, then one idle bus cycle
//   XFER  -> DRAIN : read only, wait for the last RAM byte (1-cycle RAM latency)
//   -> DONE        : done_out pulse (and rdata_out update for reads)
//   DONE  -> IDLE  : requester drops req_in on this edge, no arbitration here
//
// Ports
//   clk_in      clock
//   rst_in      synchronous active-high reset, aborts any transfer
//   rdy_in      0 freezes every register (outputs, pulses, counters, pointer)
//   req_in      per-channel request level, held until done_out[ch]
//   we_in       per-channel direction, 1 = write
//   addr_in     per-channel start byte address, channel c at [c*ADDR_W +: ADDR_W]
//   len_in      per-channel byte count minus one, channel c at [c*LEN_W +: LEN_W]
//   wdata_in    per-channel write word, byte k at [8k+7:8k] of the channel slice
//   gnt_out     one-hot pulse: request accepted
//   done_out    one-hot pulse: transfer complete
//   rdata_out   assembled read word, valid while done_out of a read is high
//   mem_din     RAM read data, one cycle after the address
//   mem_a_out   RAM byte address
//   mem_dout    RAM write data
//   mem_wr_out  RAM write enable
// -----------------------------------------------------------------------------
module mem_rr_arbiter #(
    parameter int NCH        = 3,
    parameter int ADDR_W     = 32,
    parameter int WORD_BYTES = 4,
    localparam int DATA_W    = 8 * WORD_BYTES,
    localparam int LEN_W     = $clog2(WORD_BYTES)
) (
    input  logic                  clk_in,
    input  logic                  rst_in,
    input  logic                  rdy_in,
    input  logic [NCH-1:0]        req_in,
    input  logic [NCH-1:0]        we_in,
    input  logic [NCH*ADDR_W-1:0] addr_in,
    input  logic [NCH*LEN_W-1:0]  len_in,
    input  logic [NCH*DATA_W-1:0] wdata_in,
    output logic [NCH-1:0]        gnt_out,
    output logic [NCH-1:0]        done_out,
    output logic [DATA_W-1:0]     rdata_out,
    input  logic [7:0]            mem_din,
    output logic [ADDR_W-1:0]     mem_a_out,
    output logic [7:0]            mem_dout,
    output logic                  mem_wr_out
);

    // The byte index runs up to len+2 during a read, so it needs one bit
    // more than the length field.
    localparam int CNT_W = LEN_W + 1;
    localparam int PTR_W = (NCH > 1) ? $clog2(NCH) : 1;

    typedef enum logic [1:0] {
        S_IDLE,
        S_XFER,
        S_DRAIN,
        S_DONE
    } state_t;

    // ------------------------------------------------------------------
    // Registered state
    // ------------------------------------------------------------------
    state_t              state;
    logic [PTR_W-1:0]    rr_ptr;
    logic [PTR_W-1:0]    cur_ch;
    logic                cur_we;
    logic [ADDR_W-1:0]   cur_addr;
    logic [LEN_W-1:0]    cur_len;
    logic [DATA_W-1:0]   cur_wdata;
    logic [CNT_W-1:0]    idx;      // next byte to issue
    logic [DATA_W-1:0]   rbuf;     // read bytes captured so far

    // ------------------------------------------------------------------
    // Next-state values
    // ------------------------------------------------------------------
    state_t              state_n;
    logic [PTR_W-1:0]    rr_ptr_n;
    logic [PTR_W-1:0]    cur_ch_n;
    logic                cur_we_n;
    logic [ADDR_W-1:0]   cur_addr_n;
    logic [LEN_W-1:0]    cur_len_n;
    logic [DATA_W-1:0]   cur_wdata_n;
    logic [CNT_W-1:0]    idx_n;
    logic [DATA_W-1:0]   rbuf_n;
    logic [NCH-1:0]      gnt_n;
    logic [NCH-1:0]      done_n;
    logic [DATA_W-1:0]   rdata_n;
    logic [ADDR_W-1:0]   mem_a_n;
    logic [7:0]          mem_dout_n;
    logic                mem_wr_n;

    // Arbitration result
    logic                found;
    logic [PTR_W-1:0]    pick;

    // Read capture helpers
    logic [CNT_W-1:0]    cap_sel;
    logic [DATA_W-1:0]   cap_word;

    // ------------------------------------------------------------------
    // Round-robin scan: first requester at rr_ptr, rr_ptr+1, ... mod NCH
    // ------------------------------------------------------------------
    always_comb begin
        // NOTE: every variable written here gets a default first, so no path
        // leaves it unassigned and no latch is inferred.
        found = 1'b0;
        pick  = '0;
        for (int i = 0; i < NCH; i++) begin
            int c;
            c = int'(rr_ptr) + i;
            if (c >= NCH) begin
                c = c - NCH;
            end
            if (!found && req_in[c]) begin
                found = 1'b1;
                pick  = PTR_W'(c);
            end
        end
    end

    // ------------------------------------------------------------------
    // Read capture: byte (idx-2) arrives on mem_din at the edge where idx
    // would be used; bytes above len stay 0 because rbuf is cleared at grant.
    // ------------------------------------------------------------------
    always_comb begin
        cap_sel  = idx - CNT_W'(2);
        cap_word = rbuf | (DATA_W'(mem_din) << {cap_sel, 3'b000});
    end

    // ------------------------------------------------------------------
    // Next-state and output logic
    // ------------------------------------------------------------------
    always_comb begin
        state_n     = state;
        rr_ptr_n    = rr_ptr;
        cur_ch_n    = cur_ch;
        cur_we_n    = cur_we;
        cur_addr_n  = cur_addr;
        cur_len_n   = cur_len;
        cur_wdata_n = cur_wdata;
        idx_n       = idx;
        rbuf_n      = rbuf;
        rdata_n     = rdata_out;
        gnt_n       = '0;
        done_n      = '0;
        mem_a_n     = '0;
        mem_dout_n  = '0;
        mem_wr_n    = 1'b0;

        unique case (state)
            S_IDLE: begin
                if (found) begin
                    cur_ch_n    = pick;
                    cur_we_n    = we_in[pick];
                    cur_addr_n  = addr_in[pick*ADDR_W +: ADDR_W];
                    cur_len_n   = len_in[pick*LEN_W +: LEN_W];
                    cur_wdata_n = wdata_in[pick*DATA_W +: DATA_W];
                    gnt_n[pick] = 1'b1;
                    rr_ptr_n    = (pick == PTR_W'(NCH - 1)) ? '0 : pick + PTR_W'(1);
                    rbuf_n      = '0;
                    idx_n       = CNT_W'(1);
                    // Byte 0 goes out on the grant edge straight from the inputs.
                    mem_a_n     = addr_in[pick*ADDR_W +: ADDR_W];
                    mem_wr_n    = we_in[pick];
                    mem_dout_n  = we_in[pick] ? wdata_in[pick*DATA_W +: 8] : 8'h00;
                    state_n     = S_XFER;
                end
            end

            S_XFER: begin
                idx_n = idx + CNT_W'(1);
                if (!cur_we && idx >= CNT_W'(2)) begin
                    rbuf_n = cap_word;
                end
                if (idx <= {1'b0, cur_len}) begin
                    mem_a_n    = cur_addr + ADDR_W'(idx);
                    mem_wr_n   = cur_we;
                    mem_dout_n = cur_we ? 8'(cur_wdata >> {idx, 3'b000}) : 8'h00;
                end else if (cur_we) begin
                    done_n[cur_ch] = 1'b1;
                    state_n        = S_DONE;
                end else begin
                    state_n = S_DRAIN;
                end
            end

            S_DRAIN: begin
                // Last read byte lands now; publish the word with done.
                rbuf_n         = cap_word;
                rdata_n        = cap_word;
                done_n[cur_ch] = 1'b1;
                state_n        = S_DONE;
            end

            S_DONE: begin
                state_n = S_IDLE;
            end

            default: begin
                state_n = S_IDLE;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // State register: reset wins over the freeze, the freeze holds everything.
    // ------------------------------------------------------------------
    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            // NOTE: the latched request fields and capture buffer are reset as
            // well; they are ordinary registers, not a RAM, so this is cheap and
            // keeps them free of X after reset.
            state      <= S_IDLE;
            rr_ptr     <= '0;
            cur_ch     <= '0;
            cur_we     <= 1'b0;
            cur_addr   <= '0;
            cur_len    <= '0;
            cur_wdata  <= '0;
            idx        <= '0;
            rbuf       <= '0;
            gnt_out    <= '0;
            done_out   <= '0;
            rdata_out  <= '0;
            mem_a_out  <= '0;
            mem_dout   <= '0;
            mem_wr_out <= 1'b0;
        end else if (rdy_in) begin
            // NOTE: non-blocking assignments so every register samples the
            // pre-edge values computed above, independent of statement order.
            state      <= state_n;
            rr_ptr     <= rr_ptr_n;
            cur_ch     <= cur_ch_n;
            cur_we     <= cur_we_n;
            cur_addr   <= cur_addr_n;
            cur_len    <= cur_len_n;
            cur_wdata  <= cur_wdata_n;
            idx        <= idx_n;
            rbuf       <= rbuf_n;
            gnt_out    <= gnt_n;
            done_out   <= done_n;
            rdata_out  <= rdata_n;
            mem_a_out  <= mem_a_n;
            mem_dout   <= mem_dout_n;
            mem_wr_out <= mem_wr_n;
        end
    end

endmodule

// File: tb/tb_mem_rr_arbiter.sv
// -----------------------------------------------------------------------------
// tb_mem_rr_arbiter
//
// Bench for mem_rr_arbiter (NCH=3, ADDR_W=32, WORD_BYTES=4). A table of single
// transactions is replayed against a byte RAM model with one cycle of read
// latency; each cycle after the grant is compared with the bus timeline the
// arbiter must produce. Hand-written sequences cover the freeze, reset abort
// and round-robin ordering under continuous contention.
// -----------------------------------------------------------------------------
module tb_mem_rr_arbiter;

    localparam int NCH    = 3;
    localparam int ADDR_W = 32;
    localparam int WB     = 4;
    localparam int DATA_W = 8 * WB;
    localparam int LEN_W  = 2;

    logic                  clk_in = 1'b0;
    logic                  rst_in;
    logic                  rdy_in;
    logic [NCH-1:0]        req_in;
    logic [NCH-1:0]        we_in;
    logic [NCH*ADDR_W-1:0] addr_in;
    logic [NCH*LEN_W-1:0]  len_in;
    logic [NCH*DATA_W-1:0] wdata_in;
    logic [NCH-1:0]        gnt_out;
    logic [NCH-1:0]        done_out;
    logic [DATA_W-1:0]     rdata_out;
    logic [7:0]            mem_din;
    logic [ADDR_W-1:0]     mem_a_out;
    logic [7:0]            mem_dout;
    logic                  mem_wr_out;

    mem_rr_arbiter #(.NCH(NCH), .ADDR_W(ADDR_W), .WORD_BYTES(WB)) dut (
        .clk_in     (clk_in),
        .rst_in     (rst_in),
        .rdy_in     (rdy_in),
        .req_in     (req_in),
        .we_in      (we_in),
        .addr_in    (addr_in),
        .len_in     (len_in),
        .wdata_in   (wdata_in),
        .gnt_out    (gnt_out),
        .done_out   (done_out),
        .rdata_out  (rdata_out),
        .mem_din    (mem_din),
        .mem_a_out  (mem_a_out),
        .mem_dout   (mem_dout),
        .mem_wr_out (mem_wr_out)
    );

    always #5 clk_in = ~clk_in;

    // RAM model: 512 bytes; unwritten bytes read back as addr[7:0]. It shares
    // the system freeze, so it holds while rdy_in is low.
    logic [7:0] ram   [512];
    bit         wflag [512];

    always @(posedge clk_in) begin
        if (rdy_in) begin
            if (mem_wr_out) begin
                ram[mem_a_out[8:0]]   <= mem_dout;
                wflag[mem_a_out[8:0]] <= 1'b1;
            end
            mem_din <= wflag[mem_a_out[8:0]] ? ram[mem_a_out[8:0]] : mem_a_out[7:0];
        end
    end

    int n_cmp = 0;
    int n_bad = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    typedef struct {
        string        name;
        int           ch;
        bit           we;
        logic [31:0]  addr;
        logic [1:0]   len;
        logic [31:0]  wdata;
        logic [31:0]  exp_rdata;   // read result, or the held value for writes
    } vec_t;

    vec_t vecs[7];

    // Expected {mem_a_out, mem_dout, mem_wr_out} k cycles after the grant edge.
    function automatic logic [40:0] exp_bus(input vec_t v, input int k);
        logic [31:0] a;
        logic [31:0] w;
        logic [7:0]  d;
        if (k > int'(v.len)) return '0;
        a = v.addr + 32'(k);
        w = v.wdata >> (8 * k);
        d = v.we ? w[7:0] : 8'h00;
        return {a, d, v.we};
    endfunction

    function automatic logic [40:0] bus_now();
        return {mem_a_out, mem_dout, mem_wr_out};
    endfunction

    task automatic wait_grant(input int budget, output bit got);
        got = 1'b0;
        for (int t = 0; t < budget && !got; t++) begin
            @(negedge clk_in);
            if (gnt_out != '0) got = 1'b1;
        end
    endtask

    task automatic load_ch(input vec_t v);
        we_in[v.ch]                    = v.we;
        addr_in[v.ch*ADDR_W +: ADDR_W] = v.addr;
        len_in[v.ch*LEN_W +: LEN_W]    = v.len;
        wdata_in[v.ch*DATA_W +: DATA_W] = v.wdata;
    endtask

    // Scramble a channel's inputs after its grant; the transfer must not notice.
    task automatic scramble_ch(input vec_t v);
        req_in[v.ch]                    = 1'b0;
        we_in[v.ch]                     = ~v.we;
        addr_in[v.ch*ADDR_W +: ADDR_W]  = ~v.addr;
        len_in[v.ch*LEN_W +: LEN_W]     = ~v.len;
        wdata_in[v.ch*DATA_W +: DATA_W] = ~v.wdata;
    endtask

    task automatic run_txn(input vec_t v);
        bit got;
        int done_k;
        logic [NCH-1:0] oh;
        oh     = NCH'(1) << v.ch;
        done_k = v.we ? int'(v.len) + 1 : int'(v.len) + 2;
        load_ch(v);
        req_in[v.ch] = 1'b1;
        wait_grant(8, got);
        check({v.name, " grant_seen"}, 64'(got), 64'd1);
        if (!got) begin
            req_in[v.ch] = 1'b0;
            return;
        end
        check({v.name, " gnt"}, 64'(gnt_out), 64'(oh));
        check({v.name, " bus c0"}, 64'(bus_now()), 64'(exp_bus(v, 0)));
        scramble_ch(v);
        for (int k = 1; k <= done_k; k++) begin
            @(negedge clk_in);
            check($sformatf("%s bus c%0d", v.name, k), 64'(bus_now()), 64'(exp_bus(v, k)));
            check($sformatf("%s gnt c%0d", v.name, k), 64'(gnt_out), 64'd0);
            check($sformatf("%s done c%0d", v.name, k), 64'(done_out),
                  (k == done_k) ? 64'(oh) : 64'd0);
        end
        check({v.name, " rdata"}, 64'(rdata_out), 64'(v.exp_rdata));
        @(negedge clk_in);
        check({v.name, " done_clear"}, 64'(done_out), 64'd0);
        check({v.name, " bus_after"}, 64'(bus_now()), 64'd0);
    endtask

    task automatic do_reset();
        rst_in = 1'b1;
        req_in = '0;
        repeat (2) @(negedge clk_in);
        rst_in = 1'b0;
    endtask

    initial begin
        vec_t s;
        bit   got;
        int   gcyc[5];
        int   gch[5];
        int   ng;

        vecs[0] = '{"rd_ch0_100_len3",  0, 1'b0, 32'h0000_0100, 2'd3, 32'h0,         32'h0302_0100};
        vecs[1] = '{"wr_ch2_20_len1",   2, 1'b1, 32'h0000_0020, 2'd1, 32'hAABB_CCDD, 32'h0302_0100};
        vecs[2] = '{"rd_ch1_wrap",      1, 1'b0, 32'hFFFF_FFFF, 2'd1, 32'h0,         32'h0000_00FF};
        vecs[3] = '{"wr_ch1_80_len3",   1, 1'b1, 32'h0000_0080, 2'd3, 32'h1122_3344, 32'h0000_00FF};
        vecs[4] = '{"rd_ch2_80_len2",   2, 1'b0, 32'h0000_0080, 2'd2, 32'h0,         32'h0022_3344};
        vecs[5] = '{"rd_ch0_21_len0",   0, 1'b0, 32'h0000_0021, 2'd0, 32'h0,         32'h0000_00CC};
        vecs[6] = '{"wr_ch0_7f_len0",   0, 1'b1, 32'h0000_007F, 2'd0, 32'h0000_00EE, 32'h0000_00CC};

        rst_in   = 1'b1;
        rdy_in   = 1'b1;
        req_in   = '0;
        we_in    = '0;
        addr_in  = '0;
        len_in   = '0;
        wdata_in = '0;
        repeat (3) @(negedge clk_in);
        check("reset gnt",   64'(gnt_out),   64'd0);
        check("reset done",  64'(done_out),  64'd0);
        check("reset rdata", 64'(rdata_out), 64'd0);
        check("reset bus",   64'(bus_now()), 64'd0);
        rst_in = 1'b0;

        // Table of single transactions
        for (int i = 0; i < 7; i++) begin
            run_txn(vecs[i]);
        end
        check("ram 0x20",      64'(ram[9'h020]),   64'hDD);
        check("ram 0x21",      64'(ram[9'h021]),   64'hCC);
        check("ram 0x22 free", 64'(wflag[9'h022]), 64'd0);

        // Freeze for 3 cycles after E1 of a 4-byte read
        s = vecs[0];
        s.name = "stall";
        load_ch(s);
        req_in[0] = 1'b1;
        wait_grant(8, got);
        check("stall grant_seen", 64'(got), 64'd1);
        scramble_ch(s);
        @(negedge clk_in);
        check("stall bus c1", 64'(bus_now()), 64'(exp_bus(s, 1)));
        rdy_in = 1'b0;
        for (int c = 2; c <= 4; c++) begin
            @(negedge clk_in);
            check($sformatf("stall frozen bus c%0d", c), 64'(bus_now()), {23'd0, 32'h101, 8'h00, 1'b0});
            check($sformatf("stall frozen done c%0d", c), 64'(done_out), 64'd0);
            check($sformatf("stall frozen rdata c%0d", c), 64'(rdata_out), 64'h0000_00CC);
        end
        rdy_in = 1'b1;
        for (int c = 5; c <= 8; c++) begin
            @(negedge clk_in);
            check($sformatf("stall bus c%0d", c), 64'(bus_now()), 64'(exp_bus(s, c - 3)));
            check($sformatf("stall done c%0d", c), 64'(done_out), (c == 8) ? 64'd1 : 64'd0);
        end
        check("stall rdata", 64'(rdata_out), 64'h0302_0100);
        @(negedge clk_in);

        // Reset after two write bytes of ch1, then ch1 and ch2 pending
        s = '{"abort", 1, 1'b1, 32'h0000_0140, 2'd3, 32'h9988_7766, 32'h0};
        load_ch(s);
        req_in[1] = 1'b1;
        wait_grant(8, got);
        check("abort grant_seen", 64'(got), 64'd1);
        check("abort gnt", 64'(gnt_out), 64'b010);
        @(negedge clk_in);
        check("abort bus c1", 64'(bus_now()), {23'd0, 32'h141, 8'h77, 1'b1});
        req_in[2] = 1'b1;
        rst_in    = 1'b1;
        @(negedge clk_in);
        check("abort wr after rst",  64'(mem_wr_out), 64'd0);
        check("abort bus after rst", 64'(bus_now()),  64'd0);
        check("abort no done",       64'(done_out),   64'd0);
        rst_in = 1'b0;
        @(negedge clk_in);
        check("abort regrant ch1", 64'(gnt_out),   64'b010);
        check("abort regrant bus", 64'(bus_now()), {23'd0, 32'h140, 8'h66, 1'b1});
        do_reset();

        // Continuous contention, all reads len=0: expect 0,1,2,0,1 every 4 cycles
        for (int c = 0; c < NCH; c++) begin
            s = '{"rr", c, 1'b0, 32'h10 + 32'(c), 2'd0, 32'h0, 32'h0};
            load_ch(s);
        end
        req_in = '1;
        ng = 0;
        for (int t = 0; t < 60 && ng < 5; t++) begin
            @(negedge clk_in);
            if (gnt_out != '0) begin
                gcyc[ng] = t;
                gch[ng]  = (gnt_out == 3'b001) ? 0 : (gnt_out == 3'b010) ? 1 :
                           (gnt_out == 3'b100) ? 2 : -1;
                ng++;
            end
        end
        req_in = '0;
        check("rr grant count", 64'(ng), 64'd5);
        for (int g = 0; g < ng; g++) begin
            check($sformatf("rr grant %0d ch", g), 64'(gch[g]), 64'(g % NCH));
            if (g > 0) check($sformatf("rr grant %0d spacing", g), 64'(gcyc[g] - gcyc[g-1]), 64'd4);
        end
        do_reset();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
